am_demod: RTL and testbench

AM_DEMOD -- requirements
Module: am_demod

---
 rtl/am_demod_if.sv | 44 ++++
 rtl/am_demod.sv | 236 +++++++++++++++++++++++
 tb/tb_am_demod.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/am_demod_if.sv
// ---------------------------------------------------------------------------
// am_demod_if -- sample-stream bundle for the AM demodulator.
//
// Signals
//   ammod_in    [7:0]          unsigned modulated sample, mid-scale 127 = zero
//   in_valid                   qualifies ammod_in for one cycle
//   phase_inc   [PHASE_W-1:0]  carrier phase step applied per accepted sample
//   demod_out   [7:0]          signed demodulated baseband
//   demod_valid                one-cycle strobe marking a new demod_out value
//
// Handshake: the stream has no ready. A sample is transferred on every clk
// rising edge where in_valid=1; the consumer never stalls the producer, and
// demod_valid is a pure strobe (no acknowledge). Holding data while valid is
// low carries no meaning.
//
// Modports
//   master : sample source / result sink (testbench or upstream logic)
//   slave  : the demodulator
// ---------------------------------------------------------------------------
interface am_demod_if #(
  parameter int PHASE_W = 10
);
  logic        [7:0]         ammod_in;
  logic                      in_valid;
  logic        [PHASE_W-1:0] phase_inc;
  logic signed [7:0]         demod_out;
  logic                      demod_valid;

  modport master (
    output ammod_in,
    output in_valid,
    output phase_inc,
    input  demod_out,
    input  demod_valid
  );

  modport slave (
    input  ammod_in,
    input  in_valid,
    input  phase_inc,
    output demod_out,
    output demod_valid
  );
endinterface

// File: rtl/am_demod.sv
// ---------------------------------------------------------------------------
// am_demod -- coherent AM demodulator.
//
// Each accepted sample is re-centred around zero, multiplied by a locally
// generated sine carrier, and low-pass filtered by an N-tap moving average
// (N = 2^AVG_LOG2). The averaged sum is scaled back to 8 bits.
//
// Pipeline (one register stage per row, 4 cycles input to output):
//   stage 1 : x = sat(ammod_in - 127), c = LUT[P top 8 bits], v1
//   stage 2 : p = x * c (16-bit full product), v2
//   stage 3 : circular buffer of N products, running sum S, fill count F
//   stage 4 : demod_out = sat(S >>> (AVG_LOG2+6)), demod_valid
//
// Ports
//   clk  : single clock, all registers on rising edge
//   rst  : synchronous active-high reset, clears every register
//   bus  : am_demod_if.slave (sample stream in, demodulated stream out)
//
// Handshake: a sample is taken on each edge with in_valid=1, there is no
// backpressure, and demod_valid is a one-cycle strobe. Cycles with
// in_valid=0 travel down the pipe as bubbles: every stage holds its data.
//
// The interface PHASE_W parameter must equal this module's PHASE_W.
// ---------------------------------------------------------------------------
module am_demod #(
  parameter int PHASE_W  = 10,
  parameter int AVG_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst,
  am_demod_if.slave  bus
);

  localparam int N      = 1 << AVG_LOG2;
  localparam int SUM_W  = 20;
  localparam int FILL_W = AVG_LOG2 + 1;
  // Divide by N for the average, by 128 to undo the carrier amplitude and
  // multiply by 2 to undo the 1/2 DSB mixing loss: net >>> (AVG_LOG2 + 6).
  localparam int SHIFT  = AVG_LOG2 + 6;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(N);

  // -------------------------------------------------------------------------
  // Quarter-wave sine table: round(127*sin(2*pi*j/256)) for j = 0..64.
  // -------------------------------------------------------------------------
  function automatic logic [6:0] quarter_sin(input logic [6:0] j);
    logic [6:0] v;
    v = 7'd0;
    case (j)
      7'd0:  v = 7'd0;    7'd1:  v = 7'd3;    7'd2:  v = 7'd6;
      7'd3:  v = 7'd9;    7'd4:  v = 7'd12;   7'd5:  v = 7'd16;
      7'd6:  v = 7'd19;   7'd7:  v = 7'd22;   7'd8:  v = 7'd25;
      7'd9:  v = 7'd28;   7'd10: v = 7'd31;   7'd11: v = 7'd34;
      7'd12: v = 7'd37;   7'd13: v = 7'd40;   7'd14: v = 7'd43;
      7'd15: v = 7'd46;   7'd16: v = 7'd49;   7'd17: v = 7'd51;
      7'd18: v = 7'd54;   7'd19: v = 7'd57;   7'd20: v = 7'd60;
      7'd21: v = 7'd63;   7'd22: v = 7'd65;   7'd23: v = 7'd68;
      7'd24: v = 7'd71;   7'd25: v = 7'd73;   7'd26: v = 7'd76;
      7'd27: v = 7'd78;   7'd28: v = 7'd81;   7'd29: v = 7'd83;
      7'd30: v = 7'd85;   7'd31: v = 7'd88;   7'd32: v = 7'd90;
      7'd33: v = 7'd92;   7'd34: v = 7'd94;   7'd35: v = 7'd96;
      7'd36: v = 7'd98;   7'd37: v = 7'd100;  7'd38: v = 7'd102;
      7'd39: v = 7'd104;  7'd40: v = 7'd106;  7'd41: v = 7'd107;
      7'd42: v = 7'd109;  7'd43: v = 7'd111;  7'd44: v = 7'd112;
      7'd45: v = 7'd113;  7'd46: v = 7'd115;  7'd47: v = 7'd116;
      7'd48: v = 7'd117;  7'd49: v = 7'd118;  7'd50: v = 7'd120;
      7'd51: v = 7'd121;  7'd52: v = 7'd122;  7'd53: v = 7'd122;
      7'd54: v = 7'd123;  7'd55: v = 7'd124;  7'd56: v = 7'd125;
      7'd57: v = 7'd125;  7'd58: v = 7'd126;  7'd59: v = 7'd126;
      7'd60: v = 7'd126;  7'd61: v = 7'd127;  7'd62: v = 7'd127;
      7'd63: v = 7'd127;  7'd64: v = 7'd127;
      default: v = 7'd0;
    endcase
    return v;
  endfunction

  // Full 256-entry signed carrier built from the quarter table by symmetry:
  // quadrant bit 0 mirrors the index, quadrant bit 1 negates the value.
  function automatic logic signed [7:0] carrier_lut(input logic [7:0] idx);
    logic [6:0] j;
    logic [7:0] mag;
    j   = idx[6] ? (7'd64 - {1'b0, idx[5:0]}) : {1'b0, idx[5:0]};
    mag = {1'b0, quarter_sin(j)};
    return idx[7] ? 8'(8'd0 - mag) : mag;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic        [PHASE_W-1:0] phase_q, phase_d;
  logic signed [7:0]         x_q, x_d;
  logic signed [7:0]         c_q, c_d;
  logic                      v1_q, v1_d;
  logic signed [15:0]        p_q, p_d;
  logic                      v2_q, v2_d;
  logic signed [15:0]        buf_q [N];
  logic signed [15:0]        buf_d [N];
  logic        [AVG_LOG2-1:0] wptr_q, wptr_d;
  logic signed [SUM_W-1:0]   s_q, s_d;
  logic        [FILL_W-1:0]  fill_q, fill_d;
  logic                      v3_q, v3_d;
  logic signed [7:0]         out_q, out_d;
  logic                      out_valid_q, out_valid_d;

  // -------------------------------------------------------------------------
  // Stage 1 helpers: re-centre sample, look up carrier for current phase
  // -------------------------------------------------------------------------
  logic [8:0]                diff;
  logic signed [7:0]         x_sat;
  logic signed [7:0]         carrier;

  always_comb begin
    diff = {1'b0, bus.ammod_in} - 9'd127;
    // Range is -127..128; only +128 overflows the 8-bit signed result.
    if (!diff[8] && diff[7]) begin
      x_sat = 8'sd127;
    end else begin
      x_sat = diff[7:0];
    end
    // The pre-update phase drives the carrier paired with this sample.
    carrier = carrier_lut(phase_q[PHASE_W-1 -: 8]);
  end

  // -------------------------------------------------------------------------
  // Stage 2/3/4 helpers
  // -------------------------------------------------------------------------
  logic signed [15:0]      product;
  logic signed [SUM_W-1:0] p_ext;
  logic signed [SUM_W-1:0] old_ext;
  logic signed [SUM_W-1:0] scaled;
  logic signed [7:0]       out_sat;

  always_comb begin
    product = x_q * c_q;
    p_ext   = {{(SUM_W-16){p_q[15]}}, p_q};
    old_ext = {{(SUM_W-16){buf_q[wptr_q][15]}}, buf_q[wptr_q]};
    scaled  = s_q >>> SHIFT;
    if (scaled > 20'sd127) begin
      out_sat = 8'sd127;
    end else if (scaled < -20'sd128) begin
      out_sat = -8'sd128;
    end else begin
      out_sat = scaled[7:0];
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    phase_d     = phase_q;
    x_d         = x_q;
    c_d         = c_q;
    v1_d        = bus.in_valid;
    p_d         = p_q;
    v2_d        = v1_q;
    buf_d       = buf_q;
    wptr_d      = wptr_q;
    s_d         = s_q;
    fill_d      = fill_q;
    v3_d        = v2_q;
    out_d       = out_q;
    out_valid_d = 1'b0;

    // Stage 1
    if (bus.in_valid) begin
      phase_d = phase_q + bus.phase_inc;
      x_d     = x_sat;
      c_d     = carrier;
    end

    // Stage 2
    if (v1_q) begin
      p_d = product;
    end

    // Stage 3: replace the oldest product and adjust the sum by the delta,
    // so S always equals the sum of the buffer contents.
    if (v2_q) begin
      buf_d[wptr_q] = p_q;
      wptr_d        = wptr_q + 1'b1;
      s_d           = s_q + p_ext - old_ext;
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + 1'b1;
      end
    end

    // Stage 4: reads the sum written by the previous stage-3 update.
    if (v3_q) begin
      out_d       = out_sat;
      out_valid_d = (fill_q == FILL_MAX);
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= '0;
      x_q         <= '0;
      c_q         <= '0;
      v1_q        <= 1'b0;
      p_q         <= '0;
      v2_q        <= 1'b0;
      for (int i = 0; i < N; i++) begin
        buf_q[i] <= '0;
      end
      wptr_q      <= '0;
      s_q         <= '0;
      fill_q      <= '0;
      v3_q        <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      x_q         <= x_d;
      c_q         <= c_d;
      v1_q        <= v1_d;
      p_q         <= p_d;
      v2_q        <= v2_d;
      for (int i = 0; i < N; i++) begin
        buf_q[i] <= buf_d[i];
      end
      wptr_q      <= wptr_d;
      s_q         <= s_d;
      fill_q      <= fill_d;
      v3_q        <= v3_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.demod_out   = out_q;
  assign bus.demod_valid = out_valid_q;

endmodule

// File: tb/tb_am_demod.sv
// ---------------------------------------------------------------------------
// tb_am_demod -- self-checking bench for am_demod.
// Reference model: accepted samples are turned into products with real-valued
// sine arithmetic, the output is the floored, saturated scaled sum of the
// last N products, and results are scheduled 3 edges after acceptance.
// ---------------------------------------------------------------------------
module tb_am_demod;

  localparam int PHASE_W  = 10;
  localparam int AVG_LOG2 = 4;
  localparam int N        = 16;
  localparam int EW       = 41;  // {due cycle[31:0], valid, out[7:0]}

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  am_demod_if #(.PHASE_W(PHASE_W)) bus ();

  am_demod #(
    .PHASE_W (PHASE_W),
    .AVG_LOG2(AVG_LOG2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Scoreboard / model state
  int                 checks = 0;
  int                 errors = 0;
  int                 cycle  = 0;
  int                 lut [256];
  int                 m_phase;
  int                 hist[$];
  logic [EW-1:0]      exp_q[$];
  logic               exp_valid;
  logic signed [7:0]  exp_out;
  int                 pulses;
  int                 first_pulse;

  function automatic int sat8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic int floor_div1024(input int s);
    return int'($floor(real'(s) / 1024.0));
  endfunction

  function automatic int model_sum();
    int s = 0;
    int lo = (hist.size() > N) ? hist.size() - N : 0;
    for (int i = lo; i < hist.size(); i++) s += hist[i];
    return s;
  endfunction

  function automatic int cur_idx();
    return (m_phase >> (PHASE_W - 8)) & 255;
  endfunction

  // Driver + model + per-cycle output check for one clock edge
  task automatic step(input logic r, input logic iv, input logic [7:0] a,
                      input logic [PHASE_W-1:0] inc);
    int c, x, p, s;
    logic [EW-1:0] e;
    rst           = r;
    bus.in_valid  = iv;
    bus.ammod_in  = a;
    bus.phase_inc = inc;
    @(posedge clk);
    cycle++;
    if (r) begin
      exp_q.delete();
      hist.delete();
      m_phase   = 0;
      exp_out   = '0;
      exp_valid = 1'b0;
    end else begin
      exp_valid = 1'b0;
      if (exp_q.size() > 0 && int'(exp_q[0][40:9]) == cycle) begin
        e         = exp_q.pop_front();
        exp_valid = e[8];
        exp_out   = e[7:0];
      end
      if (iv) begin
        c = lut[cur_idx()];
        x = int'(a) - 127;
        if (x > 127) x = 127;
        p = x * c;
        hist.push_back(p);
        s = model_sum();
        exp_q.push_back({32'(cycle + 3), (hist.size() >= N) ? 1'b1 : 1'b0,
                         8'(sat8(floor_div1024(s)))});
        m_phase = (m_phase + int'(inc)) % (1 << PHASE_W);
      end
    end
    #1;
    checks++;
    if (bus.demod_valid !== exp_valid) begin
      errors++;
      $display("FAIL demod_valid @cycle %0d: got %b expected %b", cycle, bus.demod_valid, exp_valid);
    end
    checks++;
    if (bus.demod_out !== exp_out) begin
      errors++;
      $display("FAIL demod_out @cycle %0d: got %0d expected %0d", cycle, bus.demod_out, exp_out);
    end
    if (bus.demod_valid === 1'b1) begin
      pulses++;
      if (first_pulse < 0) first_pulse = cycle;
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 8'd127, '0);
    pulses      = 0;
    first_pulse = -1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'($urandom_range(0, 255)), 10'd256);
  endtask

  task automatic check_end(input string name, input int exp_s, input int exp_o,
                           input int exp_pulses);
    checks++;
    if (int'(dut.s_q) !== exp_s) begin
      errors++;
      $display("FAIL %s sum: got %0d expected %0d", name, dut.s_q, exp_s);
    end
    checks++;
    if (int'(bus.demod_out) !== exp_o) begin
      errors++;
      $display("FAIL %s out: got %0d expected %0d", name, bus.demod_out, exp_o);
    end
    checks++;
    if (pulses !== exp_pulses) begin
      errors++;
      $display("FAIL %s pulses: got %0d expected %0d", name, pulses, exp_pulses);
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 8'd255, 10'd256);
    do_reset();
    checks++;
    if (bus.demod_out !== 8'sd0 || bus.demod_valid !== 1'b0 || dut.s_q !== '0) begin
      errors++;
      $display("FAIL reset_state: got out=%0d valid=%b sum=%0d expected 0 0 0",
               bus.demod_out, bus.demod_valid, dut.s_q);
    end
  endtask

  task automatic test_zero_carrier();
    int rc;
    do_reset();
    rc = cycle;
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 8'd255, 10'd0);
    drain();
    checks++;
    if (first_pulse - rc !== 19) begin
      errors++;
      $display("FAIL zero_carrier first_valid: got %0d expected %0d", first_pulse - rc, 19);
    end
    check_end("zero_carrier", 0, 0, 25);
  endtask

  task automatic test_coherent(input bit anti, input int exp_s, input int exp_o);
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, anti ? 8'(127 - lut[cur_idx()]) : 8'(127 + lut[cur_idx()]), 10'd256);
    end
    drain();
    check_end(anti ? "anti_phase" : "in_phase", exp_s, exp_o, 25);
  endtask

  task automatic test_saturated_const();
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 8'd255, 10'd256);
    drain();
    check_end("sat_const", 0, 0, 25);
  endtask

  task automatic test_bubbles();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) step(1'b0, 1'b1, 8'(127 + lut[cur_idx()]), 10'd256);
      else            step(1'b0, 1'b0, 8'($urandom_range(0, 255)), 10'd256);
    end
    drain();
    check_end("bubbles", 129032, 126, 5);
  endtask

  task automatic test_mid_reset();
    int rc;
    do_reset();
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 8'(127 + lut[cur_idx()]), 10'd256);
    step(1'b1, 1'b1, 8'd254, 10'd256);
    rc          = cycle;
    pulses      = 0;
    first_pulse = -1;
    checks++;
    if (bus.demod_out !== 8'sd0 || bus.demod_valid !== 1'b0 || dut.s_q !== '0) begin
      errors++;
      $display("FAIL mid_reset_state: got out=%0d valid=%b sum=%0d expected 0 0 0",
               bus.demod_out, bus.demod_valid, dut.s_q);
    end
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 8'(127 + lut[cur_idx()]), 10'd256);
    drain();
    checks++;
    if (first_pulse - rc !== 19) begin
      errors++;
      $display("FAIL mid_reset first_valid: got %0d expected %0d", first_pulse - rc, 19);
    end
    check_end("mid_reset", 129032, 126, 15);
  endtask

  task automatic test_random();
    logic [PHASE_W-1:0] inc;
    do_reset();
    inc = PHASE_W'($urandom_range(0, 1023));
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 49) inc = PHASE_W'($urandom_range(0, 1023));
      step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           8'($urandom_range(0, 255)), inc);
    end
    drain();
    checks++;
    if (int'(dut.s_q) !== model_sum()) begin
      errors++;
      $display("FAIL random sum: got %0d expected %0d", dut.s_q, model_sum());
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) lut[k] = int'(127.0 * $sin(2.0 * 3.14159265358979 * k / 256.0));
    m_phase     = 0;
    exp_valid   = 1'b0;
    exp_out     = '0;
    pulses      = 0;
    first_pulse = -1;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.ammod_in  = 8'd127;
    bus.phase_inc = '0;

    test_reset();
    test_zero_carrier();
    test_coherent(1'b0, 129032, 126);
    test_coherent(1'b1, -129032, -127);
    test_saturated_const();
    test_bubbles();
    test_mid_reset();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
